// File: rtl/button_events_pkg.sv
// rtl/button_events_pkg.sv - shared types and constants for the button event block
//
// Purpose: FSM state encoding and the bit order used by consumers that bundle
// the event pulses into a single vector.
package button_events_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  // Event-bus bit positions
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_SHORT   = 2;
  localparam int EV_LONG    = 3;
  localparam int EV_REPEAT  = 4;
  localparam int EV_WIDTH   = 5;

endpackage

// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - button level in, UI event pulses out
//
// Purpose: bundles the debounced button level and the event outputs.
// Ports (signals):
//   i_BTN     debounced level, 1 = pressed
//   o_PRESS   one-cycle pulse on press
//   o_RELEASE one-cycle pulse on any release
//   o_SHORT   one-cycle pulse on release before the long threshold
//   o_LONG    one-cycle pulse when the long threshold is reached
//   o_REPEAT  one-cycle pulse at each auto-repeat interval after o_LONG
//   o_HELD    level, 1 while a press is in progress
// Modports: master drives i_BTN (button source), slave drives the events.
interface button_events_if;

  logic i_BTN;
  logic o_PRESS;
  logic o_RELEASE;
  logic o_SHORT;
  logic o_LONG;
  logic o_REPEAT;
  logic o_HELD;

  modport master (
    output i_BTN,
    input  o_PRESS, o_RELEASE, o_SHORT, o_LONG, o_REPEAT, o_HELD
  );

  modport slave (
    input  i_BTN,
    output o_PRESS, o_RELEASE, o_SHORT, o_LONG, o_REPEAT, o_HELD
  );

endinterface

// File: rtl/button_events_tick_prescaler.sv
// rtl/button_events_tick_prescaler.sv - restartable clock-to-tick divider
//
// Purpose: emits one tick every p_DIVIDER enabled cycles; clear restarts the
// count so tick phase is aligned to an external event.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   clear    synchronous restart to 0 (wins over enable)
//   enable   count advances only while high
//   tick     high on the enabled cycle where count == p_DIVIDER-1
module tick_prescaler #(
  parameter int p_DIVIDER = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (p_DIVIDER > 1) ? $clog2(p_DIVIDER) : 1;

  logic [W-1:0] count;
  logic         at_end;

  assign at_end = (count == W'(p_DIVIDER - 1));
  assign tick   = enable & at_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - turns a debounced button level into UI event pulses
//
// Purpose: press / release / short-click / long-press / auto-repeat pulses,
// all registered and one cycle wide, timed in prescaler ticks that restart
// on every press.
// Ports:
//   i_SYS_CLOCK  system clock, rising edge
//   i_RESET_N    asynchronous active-low reset
//   bus          button_events_if.slave (i_BTN in, event pulses and o_HELD out)
module button_events
  import button_events_pkg::*;
#(
  parameter int p_DIVIDER      = 5,
  parameter int p_LONG_TICKS   = 3,
  parameter int p_REPEAT_TICKS = 2
) (
  input logic              i_SYS_CLOCK,
  input logic              i_RESET_N,
  button_events_if.slave   bus
);

  localparam int HMAX = (p_LONG_TICKS > p_REPEAT_TICKS) ? p_LONG_TICKS : p_REPEAT_TICKS;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  state_t        state;
  logic [HW-1:0] hold;
  logic          btn_q;
  logic          tick;
  logic          rise;
  logic          press_q, release_q, short_q, long_q, repeat_q, held_q;

  // IDLE is only entered by reset or a release, so btn_q is 0 there and a
  // level already high out of reset still counts as a rising edge.
  assign rise = bus.i_BTN & ~btn_q;

  // Clearing throughout IDLE makes the first tick land exactly p_DIVIDER
  // cycles after the press edge.
  tick_prescaler #(.p_DIVIDER(p_DIVIDER)) u_prescaler (
    .clock   (i_SYS_CLOCK),
    .reset_n (i_RESET_N),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .tick    (tick)
  );

  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state     <= IDLE;
      hold      <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      btn_q     <= bus.i_BTN;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state)
        IDLE: begin
          hold   <= '0;
          held_q <= rise;
          if (rise) begin
            press_q <= 1'b1;
            state   <= PRESSED;
          end
        end
        PRESSED: begin
          held_q <= bus.i_BTN;
          // Release is tested first so it wins over a coincident threshold tick.
          if (!bus.i_BTN) begin
            release_q <= 1'b1;
            short_q   <= 1'b1;
            hold      <= '0;
            state     <= IDLE;
          end else if (tick) begin
            if (hold == HW'(p_LONG_TICKS - 1)) begin
              long_q <= 1'b1;
              hold   <= '0;
              state  <= LONG_HELD;
            end else begin
              hold <= hold + 1'b1;
            end
          end
        end
        LONG_HELD: begin
          held_q <= bus.i_BTN;
          if (!bus.i_BTN) begin
            release_q <= 1'b1;
            hold      <= '0;
            state     <= IDLE;
          end else if (tick) begin
            if (hold == HW'(p_REPEAT_TICKS - 1)) begin
              repeat_q <= 1'b1;
              hold     <= '0;
            end else begin
              hold <= hold + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          hold   <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_PRESS   = press_q;
  assign bus.o_RELEASE = release_q;
  assign bus.o_SHORT   = short_q;
  assign bus.o_LONG    = long_q;
  assign bus.o_REPEAT  = repeat_q;
  assign bus.o_HELD    = held_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - self-checking bench for button_events
module tb_button_events;

  localparam int L = 3;
  localparam int R = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_events_if bus4 ();
  button_events_if bus1 ();

  button_events #(.p_DIVIDER(4), .p_LONG_TICKS(L), .p_REPEAT_TICKS(R)) dut4 (
    .i_SYS_CLOCK (clk),
    .i_RESET_N   (rst_n),
    .bus         (bus4.slave)
  );

  button_events #(.p_DIVIDER(1), .p_LONG_TICKS(L), .p_REPEAT_TICKS(R)) dut1 (
    .i_SYS_CLOCK (clk),
    .i_RESET_N   (rst_n),
    .bus         (bus1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a press is remembered only as "active" plus the number
  // of edges since the press edge; every event is a time rule on that age.
  int         m_div [2] = '{4, 1};
  bit         m_act [2];
  int         m_age [2];
  logic [5:0] m_exp [2];   // {press, release, short, long, repeat, held}

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (press,rel,short,long,rep,held) at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] observed(input int i);
    if (i == 0)
      return {bus4.o_PRESS, bus4.o_RELEASE, bus4.o_SHORT, bus4.o_LONG, bus4.o_REPEAT, bus4.o_HELD};
    else
      return {bus1.o_PRESS, bus1.o_RELEASE, bus1.o_SHORT, bus1.o_LONG, bus1.o_REPEAT, bus1.o_HELD};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_age[i] = 0;
      m_exp[i] = '0;
    end
  endtask

  task automatic model_edge(input logic b);
    for (int i = 0; i < 2; i++) begin
      int ld;
      int rd;
      logic [5:0] e;
      ld = L * m_div[i];
      rd = R * m_div[i];
      e  = '0;
      if (!m_act[i]) begin
        if (b) begin
          m_act[i] = 1'b1;
          m_age[i] = 0;
          e[5]     = 1'b1;
        end
      end else begin
        m_age[i]++;
        if (!b) begin
          e[4]     = 1'b1;
          e[3]     = (m_age[i] <= ld);
          m_act[i] = 1'b0;
        end else if (m_age[i] == ld) begin
          e[2] = 1'b1;
        end else if (m_age[i] > ld && ((m_age[i] - ld) % rd) == 0) begin
          e[1] = 1'b1;
        end
      end
      e[0]     = m_act[i];
      m_exp[i] = e;
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "/div4"}, observed(0), m_exp[0]);
    check({tag, "/div1"}, observed(1), m_exp[1]);
  endtask

  task automatic cyc(input logic b, input string tag);
    bus4.i_BTN = b;
    bus1.i_BTN = b;
    @(posedge clk);
    model_edge(b);
    #1;
    check_both(tag);
  endtask

  task automatic drive(input logic b, input int n, input string tag);
    for (int j = 0; j < n; j++) cyc(b, tag);
  endtask

  // Async assert between edges, observe, hold over one edge, release mid-cycle.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_both({tag, "_async"});
    @(posedge clk);
    #1;
    check_both({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    bus4.i_BTN = 1'b1;
    bus1.i_BTN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_both("reset");
    rst_n = 1'b1;

    drive(1'b1, 14, "press_out_of_reset");
    drive(1'b0, 3,  "idle");
    drive(1'b1, 5,  "short_click");
    drive(1'b0, 3,  "short_click_rel");
    drive(1'b1, 40, "long_hold");
    drive(1'b0, 3,  "long_hold_rel");
    drive(1'b1, 12, "rel_at_12");
    drive(1'b0, 2,  "rel_at_12_rel");
    drive(1'b1, 11, "rel_at_11");
    drive(1'b0, 2,  "rel_at_11_rel");
    drive(1'b1, 13, "rel_at_13");
    drive(1'b0, 2,  "rel_at_13_rel");
    drive(1'b1, 15, "reset_mid_hold");
    do_reset("reset_mid_hold");
    drive(1'b1, 20, "press_after_reset");
    drive(1'b0, 2,  "press_after_reset_rel");
    drive(1'b1, 5,  "back_to_back_a");
    drive(1'b0, 1,  "back_to_back_gap");
    drive(1'b1, 20, "back_to_back_b");
    drive(1'b0, 2,  "back_to_back_rel");

    for (int it = 0; it < 60; it++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(1, 45));
      lo = int'($urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0) begin
        drive(1'b1, hi, "rand_hold_pre_reset");
        do_reset("rand_reset");
      end else begin
        drive(1'b1, hi, "rand_hold");
      end
      drive(1'b0, lo, "rand_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
